// File: rtl/binary_to_bcd_4digit_pkg.sv
// Shared constants, FSM state type and the double-dabble digit correction
// used by the binary_to_bcd_4digit converter.
package binary_to_bcd_4digit_pkg;

    localparam int unsigned BCD_COUNTER_BITS = 14;
    localparam int unsigned BCD_DIGIT_BITS   = 4;
    localparam int unsigned BCD_DIGITS       = 4;
    localparam logic [BCD_COUNTER_BITS-1:0] BCD_VALUE_MAX = 14'd9999;

    typedef enum logic [1:0] {
        B2B_IDLE  = 2'd0,
        B2B_SHIFT = 2'd1,
        B2B_DONE  = 2'd2
    } b2b_state_e;

    // Pre-shift correction: a digit of 5 or more would exceed 9 after doubling.
    function automatic logic [BCD_DIGIT_BITS-1:0] dabble_adjust(
        input logic [BCD_DIGIT_BITS-1:0] d
    );
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/binary_to_bcd_4digit_adjust.sv
// Combinational per-digit add-3 stage; one instance per BCD digit.
module bcd_digit_adjust
    import binary_to_bcd_4digit_pkg::*;
(
    input  logic [BCD_DIGIT_BITS-1:0] digit_in,
    output logic [BCD_DIGIT_BITS-1:0] digit_out
);

    always_comb begin
        digit_out = dabble_adjust(digit_in);
    end

endmodule

// File: rtl/binary_to_bcd_4digit.sv
// Sequential double-dabble converter: one bit per clock, saturating at BCD_MAX,
// output registers update only at the end of a conversion.
module binary_to_bcd_4digit
    import binary_to_bcd_4digit_pkg::*;
#(
    parameter int unsigned          BIN_BITS = BCD_COUNTER_BITS,
    parameter int unsigned          DIGITS   = BCD_DIGITS,
    parameter logic [BIN_BITS-1:0]  BCD_MAX  = BIN_BITS'(BCD_VALUE_MAX)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [BIN_BITS-1:0]            bin_in,
    input  logic                           start,
    output logic                           busy,
    output logic                           valid,
    output logic [BCD_DIGIT_BITS*DIGITS-1:0] bcd,
    output logic                           overflow
);

    localparam int unsigned BCD_W = BCD_DIGIT_BITS * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_BITS + 1);

    b2b_state_e          state_q,    state_d;
    logic [BIN_BITS-1:0] bin_q,      bin_d;
    logic [BCD_W-1:0]    scratch_q,  scratch_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                ovf_q,      ovf_d;
    logic [BCD_W-1:0]    bcd_q,      bcd_d;
    logic                overflow_q, overflow_d;
    logic                valid_q,    valid_d;

    logic [BCD_W-1:0]    scratch_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (scratch_q[g*BCD_DIGIT_BITS +: BCD_DIGIT_BITS]),
            .digit_out (scratch_adj[g*BCD_DIGIT_BITS +: BCD_DIGIT_BITS])
        );
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;

        unique case (state_q)
            B2B_IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_BITS);
                    ovf_d     = (bin_in > BCD_MAX);
                    state_d   = B2B_SHIFT;
                end
            end
            B2B_SHIFT: begin
                // Bits leaving the top of scratch are only lost on overflow,
                // which the saturation in DONE masks anyway.
                {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = B2B_DONE;
                end
            end
            B2B_DONE: begin
                bcd_d      = ovf_q ? {DIGITS{4'h9}} : scratch_q;
                overflow_d = ovf_q;
                valid_d    = 1'b1;
                state_d    = B2B_IDLE;
            end
            default: begin
                state_d = B2B_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= B2B_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign busy     = (state_q == B2B_SHIFT);
    assign valid    = valid_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_4digit.sv
// Directed bench for binary_to_bcd_4digit: reset, corners, ignored start and
// input changes, back-to-back conversions, mid-conversion reset, counter chain.
module tb_binary_to_bcd_4digit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] bin_in = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        valid;
    logic [15:0] bcd;
    logic        overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    binary_to_bcd_4digit #(
        .BIN_BITS (14),
        .DIGITS   (4),
        .BCD_MAX  (14'd9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .valid    (valid),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus driver: one-cycle start, then observe up to 40 cycles.
    task automatic run_conv(input logic [13:0] v, output logic [15:0] bcd_s,
                            output logic ovf_s, output int lat,
                            output int busy_n, output int valid_n);
        logic got = 1'b0;
        bcd_s = '0; ovf_s = 1'b0; lat = 0; busy_n = 0; valid_n = 0;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_n++;
            tick();
            if (valid) begin
                valid_n++;
                if (!got) begin
                    got = 1'b1; lat = c; bcd_s = bcd; ovf_s = overflow;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if ({busy, valid, overflow, bcd} !== 19'd0) begin
            $display("FAIL reset_state: busy=%b valid=%b ovf=%b bcd=%h, want all zero",
                     busy, valid, overflow, bcd);
        end else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] b; logic o; int lat, bn, vn;
        run_conv(14'd1234, b, o, lat, bn, vn);
        total_cnt++;
        if (b !== 16'h1234) $display("FAIL basic_bcd: got %h want 1234", b); else pass_cnt++;
        total_cnt++;
        if (o !== 1'b0) $display("FAIL basic_ovf: got %b want 0", o); else pass_cnt++;
        total_cnt++;
        if (lat !== 15) $display("FAIL basic_latency: got %0d want 15", lat); else pass_cnt++;
        total_cnt++;
        if (bn !== 14) $display("FAIL basic_busy_cycles: got %0d want 14", bn); else pass_cnt++;
        total_cnt++;
        if (vn !== 1) $display("FAIL basic_valid_pulses: got %0d want 1", vn); else pass_cnt++;
    endtask

    task automatic test_corners();
        logic [13:0] vin [4] = '{14'd0, 14'd9999, 14'd10000, 14'd16383};
        logic [15:0] eb  [4] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
        logic        eo  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] b; logic o; int lat, bn, vn;
        for (int i = 0; i < 4; i++) begin
            run_conv(vin[i], b, o, lat, bn, vn);
            total_cnt++;
            if (b !== eb[i] || o !== eo[i] || lat !== 15) begin
                $display("FAIL corner_%0d: bcd=%h ovf=%b lat=%0d, want bcd=%h ovf=%b lat=15",
                         vin[i], b, o, lat, eb[i], eo[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_ignore_inputs();
        logic [15:0] b = '0; int vn = 0; int lat = 0;
        bin_in = 14'd567;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        start  = 1'b1;
        bin_in = 14'd8888;
        tick();
        start  = 1'b0;
        for (int c = 5; c <= 44; c++) begin
            if (c == 8) bin_in = 14'd1111;
            tick();
            if (valid) begin
                vn++;
                if (vn == 1) begin b = bcd; lat = c; end
            end
        end
        total_cnt++;
        if (b !== 16'h0567) $display("FAIL ignore_bcd: got %h want 0567", b); else pass_cnt++;
        total_cnt++;
        if (vn !== 1) $display("FAIL ignore_valid_pulses: got %0d want 1", vn); else pass_cnt++;
        total_cnt++;
        if (lat !== 15) $display("FAIL ignore_latency: got %0d want 15", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] vals [3] = '{14'd5, 14'd4, 14'd3};
        logic [15:0] exp_b [3] = '{16'h0005, 16'h0004, 16'h0003};
        logic [15:0] held = 16'h0567;
        int idx = 0, last_t = 0, gaps_bad = 0, hold_bad = 0;
        bin_in = vals[0];
        start  = 1'b1;
        for (int t = 1; t <= 80 && idx < 3; t++) begin
            tick();
            if (valid) begin
                total_cnt++;
                if (bcd !== exp_b[idx]) $display("FAIL b2b_result_%0d: got %h want %h", idx, bcd, exp_b[idx]);
                else pass_cnt++;
                if (idx > 0 && (t - last_t) != 16) gaps_bad++;
                last_t = t;
                held   = exp_b[idx];
                idx++;
                if (idx < 3) bin_in = vals[idx];
                else start = 1'b0;
            end else if (bcd !== held) begin
                hold_bad++;
            end
        end
        start = 1'b0;
        total_cnt++;
        if (idx !== 3) $display("FAIL b2b_pulse_count: got %0d want 3", idx); else pass_cnt++;
        total_cnt++;
        if (gaps_bad !== 0) $display("FAIL b2b_spacing: %0d gaps differ from 16 cycles, want 0", gaps_bad);
        else pass_cnt++;
        total_cnt++;
        if (hold_bad !== 0) $display("FAIL b2b_hold: bcd changed %0d times between pulses, want 0", hold_bad);
        else pass_cnt++;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] b; logic o; int lat, bn, vn;
        int stray = 0;
        bin_in = 14'd777;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({busy, valid, overflow, bcd} !== 19'd0) begin
            $display("FAIL midreset_state: busy=%b valid=%b ovf=%b bcd=%h, want all zero",
                     busy, valid, overflow, bcd);
        end else pass_cnt++;
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid || busy) stray++;
        end
        total_cnt++;
        if (stray !== 0) $display("FAIL midreset_no_pulse: got %0d active cycles want 0", stray);
        else pass_cnt++;
        run_conv(14'd42, b, o, lat, bn, vn);
        total_cnt++;
        if (b !== 16'h0042 || o !== 1'b0) $display("FAIL midreset_after: got %h/%b want 0042/0", b, o);
        else pass_cnt++;
    endtask

    task automatic test_counter_chain();
        logic [15:0] b; logic o; int lat, bn, vn;
        int count = 20;
        int bad = 0;
        logic [15:0] e;
        for (int k = 0; k < 23; k++) begin
            run_conv(14'(count), b, o, lat, bn, vn);
            e = {8'h00, 4'(count / 10), 4'(count % 10)};
            if (b !== e || vn !== 1) begin
                bad++;
                $display("FAIL chain_step_%0d: got %h want %h", k, b, e);
            end
            if (count > 0) count--;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL chain_sequence: %0d bad steps want 0", bad); else pass_cnt++;
        total_cnt++;
        if (bcd !== 16'h0000) $display("FAIL chain_final: got %h want 0000", bcd); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid();
        test_counter_chain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
